// File: rtl/cnn_cell_mac_seq_pkg.sv
// Shared types and helpers for the sequential CNN cell MAC engine.
package cnn_pkg;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_FINAL = 2'd2;
    localparam state_t ST_OUT   = 2'd3;

    localparam logic MODE_RAW = 1'b0;
    localparam logic MODE_Q   = 1'b1;

    // Working width of the round/saturate helper; must cover any accumulator width in use.
    localparam int RS_W = 128;

    typedef struct packed {
        logic                   sat;
        logic signed [RS_W-1:0] val;
    } rs_t;

    function automatic int acc_width(input int width, input int taps);
        return 2 * width + $clog2(2 * taps + 2);
    endfunction

    // Round half up by dropping frac bits, then clip to a signed width-bit range.
    function automatic rs_t round_sat(input logic signed [RS_W-1:0] s,
                                      input int frac, input int width);
        rs_t                    res;
        logic signed [RS_W-1:0] half;
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        half    = RS_W'(1) <<< (frac - 1);
        r       = (s + half) >>> frac;
        hi      = (RS_W'(1) <<< (width - 1)) - RS_W'(1);
        lo      = ~hi;
        res.sat = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.val = hi;
            res.sat = 1'b1;
        end else if (r < lo) begin
            res.val = lo;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cnn_cell_mac_seq_if.sv
// Operand/result handshake bundle of the CNN cell MAC engine.
interface cnn_cell_mac_seq_if #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    mode;
    logic [TAPS*WIDTH-1:0]   a_taps;
    logic [TAPS*WIDTH-1:0]   b_taps;
    logic [TAPS*WIDTH-1:0]   y_taps;
    logic [TAPS*WIDTH-1:0]   u_taps;
    logic [WIDTH-1:0]        bias;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*WIDTH-1:0]      out_data;
    logic                    out_sat;

    modport master (
        output in_valid, mode, a_taps, b_taps, y_taps, u_taps, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, mode, a_taps, b_taps, y_taps, u_taps, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/cnn_cell_mac_seq_mac_pair.sv
// Combinational A*Y + B*U for one template tap, full precision.
module cnn_mac_pair #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0]   i_a,
    input  logic signed [WIDTH-1:0]   i_y,
    input  logic signed [WIDTH-1:0]   i_b,
    input  logic signed [WIDTH-1:0]   i_u,
    output logic signed [2*WIDTH:0]   o_sum
);
    logic signed [2*WIDTH-1:0] w_ay;
    logic signed [2*WIDTH-1:0] w_bu;

    assign w_ay  = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_y);
    assign w_bu  = (2*WIDTH)'(i_b) * (2*WIDTH)'(i_u);
    assign o_sum = (2*WIDTH+1)'(w_ay) + (2*WIDTH+1)'(w_bu);
endmodule

// File: rtl/cnn_cell_mac_seq.sv
// Sequential CNN cell state engine: one A*Y + B*U pair per cycle over TAPS taps.
module cnn_cell_mac_seq
    import cnn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAPS  = 9,
    parameter int FRAC  = 8,
    parameter int ACC_W = acc_width(WIDTH, TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    cnn_cell_mac_seq_if.slave bus
);
    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int OUT_W = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

    state_t                    r_state;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_mode;
    logic [TAPS*WIDTH-1:0]     r_a;
    logic [TAPS*WIDTH-1:0]     r_b;
    logic [TAPS*WIDTH-1:0]     r_y;
    logic [TAPS*WIDTH-1:0]     r_u;
    logic signed [WIDTH-1:0]   r_bias;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_out_valid;
    logic signed [OUT_W-1:0]   r_out_data;
    logic                      r_out_sat;

    logic signed [WIDTH-1:0]   w_a;
    logic signed [WIDTH-1:0]   w_b;
    logic signed [WIDTH-1:0]   w_y;
    logic signed [WIDTH-1:0]   w_u;
    logic signed [2*WIDTH:0]   w_pair;
    logic signed [ACC_W-1:0]   w_sum_raw;
    logic signed [ACC_W-1:0]   w_sum_q;
    rs_t                       w_rs;
    logic                      w_unused;

    // Tap select over the latched operand vectors.
    assign w_a = r_a[r_idx*WIDTH +: WIDTH];
    assign w_b = r_b[r_idx*WIDTH +: WIDTH];
    assign w_y = r_y[r_idx*WIDTH +: WIDTH];
    assign w_u = r_u[r_idx*WIDTH +: WIDTH];

    cnn_mac_pair #(.WIDTH(WIDTH)) u_mac (
        .i_a   (w_a),
        .i_y   (w_y),
        .i_b   (w_b),
        .i_u   (w_u),
        .o_sum (w_pair)
    );

    // Mode 1 aligns the integer bias to the Q-format binary point before rounding.
    assign w_sum_raw = r_acc + ACC_W'(r_bias);
    assign w_sum_q   = r_acc + (ACC_W'(r_bias) <<< FRAC);
    assign w_rs      = round_sat(RS_W'(w_sum_q), FRAC, WIDTH);
    assign w_unused  = ^{w_sum_raw[ACC_W-1:OUT_W], w_rs.val[RS_W-1:OUT_W]};

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a_taps;
                        r_b     <= bus.b_taps;
                        r_y     <= bus.y_taps;
                        r_u     <= bus.u_taps;
                        r_bias  <= bus.bias;
                        r_mode  <= bus.mode;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    r_acc <= r_acc + ACC_W'(w_pair);
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    if (r_mode == MODE_Q) begin
                        r_out_data <= OUT_W'(w_rs.val);
                        r_out_sat  <= w_rs.sat;
                    end else begin
                        r_out_data <= OUT_W'(w_sum_raw);
                        r_out_sat  <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_cell_mac_seq.sv
// Bench for cnn_cell_mac_seq: reference model, per-cycle scoreboard, directed vectors.
module tb_cnn_cell_mac_seq;
    localparam int W  = 16;
    localparam int T  = 9;
    localparam int F  = 8;
    localparam int OW = 2 * W;

    typedef struct packed {
        logic signed [63:0] d;
        logic               s;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnn_cell_mac_seq_if #(.WIDTH(W), .TAPS(T)) bus ();

    cnn_cell_mac_seq #(.WIDTH(W), .TAPS(T), .FRAC(F)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t e_cur;
    int   lat = -1;

    logic [T*W-1:0] va, vb, vy, vu;
    logic [W-1:0]   vbias;
    logic           vmode;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // Reference: plain integer evaluation of the cell equation.
    function automatic exp_t model(input logic m, input logic [T*W-1:0] a, b, y, u,
                                   input logic [W-1:0] bi);
        exp_t              e;
        longint            acc;
        longint            bl;
        longint            s;
        longint            r;
        longint            lmax;
        longint            lmin;
        logic signed [OW-1:0] wrap;
        acc = 0;
        for (int k = 0; k < T; k++) begin
            acc += longint'($signed(a[k*W +: W])) * longint'($signed(y[k*W +: W]))
                 + longint'($signed(b[k*W +: W])) * longint'($signed(u[k*W +: W]));
        end
        bl = longint'($signed(bi));
        if (m == 1'b0) begin
            wrap = OW'(acc + bl);
            e.d  = longint'(wrap);
            e.s  = 1'b0;
        end else begin
            s    = acc + bl * (longint'(1) << F);
            r    = (s + (longint'(1) << (F - 1))) >>> F;
            lmax = (longint'(1) << (W - 1)) - 1;
            lmin = -(longint'(1) << (W - 1));
            e.s  = 1'b0;
            e.d  = r;
            if (r > lmax) begin
                e.d = lmax;
                e.s = 1'b1;
            end else if (r < lmin) begin
                e.d = lmin;
                e.s = 1'b1;
            end
        end
        return e;
    endfunction

    // Scoreboard, sampled on the falling edge: accepts, latency, result handshakes.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            lat = -1;
        end else begin
            if (lat >= 0) lat++;
            if (bus.out_valid && lat >= 0) begin
                check("latency", lat, T + 2);
                lat = -1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0d with no transaction pending",
                             $signed(bus.out_data));
                end else begin
                    e_cur = q.pop_front();
                    check("out_data", longint'($signed(bus.out_data)), e_cur.d);
                    check("out_sat", longint'(bus.out_sat), longint'(e_cur.s));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.mode, bus.a_taps, bus.b_taps, bus.y_taps,
                                  bus.u_taps, bus.bias));
                lat = 0;
            end
        end
    end

    task automatic load_uniform(input logic m, input logic [W-1:0] a, y, b, u, bi);
        for (int k = 0; k < T; k++) begin
            va[k*W +: W] = a;
            vy[k*W +: W] = y;
            vb[k*W +: W] = b;
            vu[k*W +: W] = u;
        end
        vbias = bi;
        vmode = m;
    endtask

    task automatic load_tap0(input logic m, input logic [W-1:0] a, y, b, u, bi);
        load_uniform(m, '0, '0, '0, '0, bi);
        va[W-1:0] = a;
        vy[W-1:0] = y;
        vb[W-1:0] = b;
        vu[W-1:0] = u;
    endtask

    task automatic load_ramp(input logic m);
        for (int k = 0; k < T; k++) begin
            va[k*W +: W] = W'(k * 37 - 150);
            vy[k*W +: W] = W'(3000 - k * 1000);
            vb[k*W +: W] = W'(k);
            vu[k*W +: W] = W'(-7);
        end
        vbias = W'(-300);
        vmode = m;
    endtask

    task automatic pin(input string name, input longint d, input logic s);
        exp_t e;
        e = model(vmode, va, vb, vy, vu, vbias);
        check({name, "_model_d"}, e.d, d);
        check({name, "_model_s"}, longint'(e.s), longint'(s));
    endtask

    task automatic apply();
        bus.mode   = vmode;
        bus.a_taps = va;
        bus.b_taps = vb;
        bus.y_taps = vy;
        bus.u_taps = vu;
        bus.bias   = vbias;
    endtask

    // Garbage on the operand pins after accept must not disturb the running sum.
    task automatic scramble();
        for (int k = 0; k < T; k++) begin
            bus.a_taps[k*W +: W] = W'($urandom);
            bus.b_taps[k*W +: W] = W'($urandom);
            bus.y_taps[k*W +: W] = W'($urandom);
            bus.u_taps[k*W +: W] = W'($urandom);
        end
        bus.bias = W'($urandom);
        bus.mode = 1'($urandom);
    endtask

    task automatic send();
        int n;
        apply();
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail_timeout("accept");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        scramble();
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while ((q.size() != 0 || bus.out_valid) && n < 100);
        if (n >= 100) fail_timeout("drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        load_uniform(1'b0, '0, '0, '0, '0, '0);
        apply();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", longint'(bus.in_ready), 1);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'($signed(bus.out_data)), 0);
        check("rst_out_sat", longint'(bus.out_sat), 0);

        load_uniform(1'b0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
        pin("raw", 131, 1'b0);
        send();
        drain();

        load_tap0(1'b0, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000, 16'hFFFF);
        pin("edge", -32768, 1'b0);
        send();
        drain();

        load_tap0(1'b1, 16'h0100, 16'h0180, 16'h0000, 16'h0000, 16'h0040);
        pin("round", 448, 1'b0);
        send();
        drain();

        load_uniform(1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        pin("sat_hi", 32767, 1'b1);
        send();
        drain();

        load_uniform(1'b1, 16'h8001, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF);
        pin("sat_lo", -32768, 1'b1);
        send();
        drain();

        load_ramp(1'b0);
        send();
        drain();
        load_ramp(1'b1);
        send();
        drain();

        // Backpressure: result held, next operand set ignored until the handshake.
        bus.out_ready = 1'b0;
        load_uniform(1'b0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
        send();
        n = 0;
        while (!bus.out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.out_valid) fail_timeout("bp_out_valid");
        load_tap0(1'b0, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000, 16'hFFFF);
        apply();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", longint'(bus.out_valid), 1);
            check("bp_data", longint'($signed(bus.out_data)), 131);
            check("bp_in_ready", longint'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        check("bp_next_accepted", longint'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        scramble();
        drain();

        // Reset in the 4th ACCUM cycle discards the operation.
        load_uniform(1'b0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
        send();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", longint'(bus.out_valid), 0);
        check("midrst_in_ready", longint'(bus.in_ready), 1);
        repeat (T + 4) @(posedge clk);
        #1;
        check("midrst_no_result", longint'(bus.out_valid), 0);
        load_uniform(1'b0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
        send();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
